// File: rtl/i2s_source_arbiter.sv
// rtl/i2s_source_arbiter.sv - round-robin arbiter sharing one I2S AXI-Stream path among up to eight sources
module i2s_source_arbiter #(
  parameter int WORD_LENGTH = 16,
  parameter int NUM_SRC     = 4,
  parameter int IDLE_LIMIT  = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC*WORD_LENGTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]             src_valid,
  output logic [NUM_SRC-1:0]             src_ready,
  input  logic [NUM_SRC-1:0]             src_enable,
  output logic [WORD_LENGTH-1:0]         m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [2:0]                     m_src,
  output logic                           underrun
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                 r_state;
  logic [2:0]             r_last_grant;
  logic [15:0]            r_idle_cnt;

  logic [NUM_SRC-1:0]     w_req;
  logic                   w_any_req;
  logic [2:0]             w_winner;
  logic [WORD_LENGTH-1:0] w_win_data;
  int                     w_dist;
  int                     w_best;

  // Distance 0 is the source just after the last grant; the smallest distance wins.
  always_comb begin
    w_req      = src_valid & src_enable;
    w_any_req  = |w_req;
    w_winner   = '0;
    w_win_data = '0;
    w_best     = NUM_SRC;
    w_dist     = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_dist = (i + NUM_SRC - 1 - int'(r_last_grant)) % NUM_SRC;
      if (w_req[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        w_winner = 3'(i);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_winner == 3'(i)) begin
        w_win_data = src_data[i*WORD_LENGTH +: WORD_LENGTH];
      end
    end
  end

  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = (r_state == ST_IDLE) && w_any_req && (w_winner == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_INIT;
      r_last_grant <= 3'(NUM_SRC - 1);
      r_idle_cnt   <= '0;
      m_data       <= '0;
      m_valid      <= 1'b0;
      m_src        <= 3'(NUM_SRC - 1);
      underrun     <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (r_state)
        ST_INIT: begin
          r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (w_any_req) begin
            m_data       <= w_win_data;
            m_valid      <= 1'b1;
            m_src        <= w_winner;
            r_last_grant <= w_winner;
            r_idle_cnt   <= '0;
            r_state      <= ST_HOLD;
          end else if (r_idle_cnt == 16'(IDLE_LIMIT - 1)) begin
            underrun   <= 1'b1;
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
          end
        end
        ST_HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_source_arbiter.sv
// tb/tb_i2s_source_arbiter.sv - vector, directed and randomized checks of i2s_source_arbiter against a behavioural model
module tb_i2s_source_arbiter;
  localparam int WL = 16;
  localparam int NS = 4;
  localparam int IL = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NS*WL-1:0]  src_data;
  logic [NS-1:0]     src_valid = '0;
  logic [NS-1:0]     src_ready;
  logic [NS-1:0]     src_enable = '0;
  logic [WL-1:0]     m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [2:0]        m_src;
  logic              underrun;
  logic [WL-1:0]     d [NS];

  int checks   = 0;
  int failures = 0;

  bit md_init, md_busy, md_und;
  int md_word, md_src, md_last, md_starve;
  logic [NS-1:0] ready_seen;

  typedef struct packed {
    logic [3:0]  v;
    logic [3:0]  e;
    logic        r;
    logic [3:0]  xr;
    logic        xv;
    logic [2:0]  xs;
    logic [15:0] xd;
  } vec_t;
  vec_t tbl [17];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NS; i++) src_data[i*WL +: WL] = d[i];
  end

  i2s_source_arbiter #(.WORD_LENGTH(WL), .NUM_SRC(NS), .IDLE_LIMIT(IL)) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .src_enable(src_enable), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_src(m_src), .underrun(underrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find_winner();
    logic [NS-1:0] req;
    int idx;
    req = src_valid & src_enable;
    for (int k = 1; k <= NS; k++) begin
      idx = (md_last + k) % NS;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NS-1:0] model_ready();
    logic [NS-1:0] r;
    int w;
    r = '0;
    if (!md_init && !md_busy) begin
      w = find_winner();
      if (w >= 0) r[w] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_reset();
    md_init = 1; md_busy = 0; md_und = 0;
    md_word = 0; md_src = NS - 1; md_last = NS - 1; md_starve = 0;
  endtask

  task automatic model_update();
    int w;
    md_und = 0;
    if (md_init) md_init = 0;
    else if (md_busy) begin
      if (m_ready) md_busy = 0;
    end else begin
      w = find_winner();
      if (w >= 0) begin
        md_busy = 1; md_word = int'(d[w]); md_src = w; md_last = w; md_starve = 0;
      end else begin
        md_starve++;
        if (md_starve % IL == 0) md_und = 1;
      end
    end
  endtask

  // Inputs are already applied; sample ready before the edge, outputs 1 time unit after it.
  task automatic cycle();
    #1;
    ready_seen = src_ready;
    chk("src_ready", 32'(src_ready), 32'(model_ready()));
    @(posedge clk);
    model_update();
    #1;
    chk("m_valid", 32'(m_valid), 32'(md_busy));
    chk("m_src", 32'(m_src), 32'(md_src));
    chk("m_data", 32'(m_data), 32'(md_word));
    chk("underrun", 32'(underrun), 32'(md_und));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_src_ready", 32'(src_ready), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      chk("rst_m_src", 32'(m_src), 32'd3);
    end
    rst = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 3'd3, 16'h0000};
    tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 3'd0, 16'h1000};
    tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 3'd0, 16'h1000};
    tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 3'd1, 16'h1001};
    tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 3'd1, 16'h1001};
    tbl[5]  = '{4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 3'd2, 16'h1002};
    tbl[6]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 3'd2, 16'h1002};
    tbl[7]  = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 3'd3, 16'h1003};
    tbl[8]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 3'd3, 16'h1003};
    tbl[9]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 3'd0, 16'h1000};
    tbl[10] = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 3'd0, 16'h1000};
    tbl[11] = '{4'h2, 4'hF, 1'b1, 4'h2, 1'b1, 3'd1, 16'h1001};
    tbl[12] = '{4'h9, 4'hF, 1'b1, 4'h0, 1'b0, 3'd1, 16'h1001};
    tbl[13] = '{4'h9, 4'hF, 1'b1, 4'h8, 1'b1, 3'd3, 16'h1003};
    tbl[14] = '{4'h9, 4'hF, 1'b1, 4'h0, 1'b0, 3'd3, 16'h1003};
    tbl[15] = '{4'h9, 4'hF, 1'b1, 4'h1, 1'b1, 3'd0, 16'h1000};
    tbl[16] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 3'd0, 16'h1000};

    for (int i = 0; i < NS; i++) d[i] = 16'(16'h1000 + i);
    src_valid = 4'hF;
    src_enable = 4'hF;
    m_ready = 1'b1;
    do_reset();

    // Round-robin and skip logic vectors, starting with the INIT cycle.
    for (int n = 0; n < 17; n++) begin
      src_valid  = tbl[n].v;
      src_enable = tbl[n].e;
      m_ready    = tbl[n].r;
      cycle();
      chk("tbl_ready", 32'(ready_seen), 32'(tbl[n].xr));
      chk("tbl_valid", 32'(m_valid), 32'(tbl[n].xv));
      chk("tbl_src", 32'(m_src), 32'(tbl[n].xs));
      chk("tbl_data", 32'(m_data), 32'(tbl[n].xd));
    end

    // Backpressure with source 2 disabled mid-hold.
    d[2] = 16'hBEEF;
    src_valid = 4'b0100;
    m_ready = 1'b0;
    cycle();
    chk("bp_grant", 32'(m_src), 32'd2);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) src_enable = 4'b1011;
      cycle();
      chk("bp_hold_data", 32'(m_data), 32'hBEEF);
      chk("bp_hold_valid", 32'(m_valid), 32'd1);
      chk("bp_ready_low", 32'(ready_seen), 32'd0);
    end
    m_ready = 1'b1;
    cycle();
    chk("bp_delivered", 32'(m_valid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("bp_no_regrant", 32'(ready_seen), 32'd0);
      chk("bp_no_valid", 32'(m_valid), 32'd0);
    end
    src_enable = 4'hF;
    src_valid = 4'h0;

    // Underrun while starved.
    do_reset();
    cycle();
    for (int k = 1; k <= 20; k++) begin
      cycle();
      chk("underrun_starve", 32'(underrun), 32'((k == 8) || (k == 16)));
    end

    // A request on the expiry cycle wins over the timeout.
    do_reset();
    cycle();
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) src_valid = 4'b0010;
      cycle();
    end
    chk("expiry_no_underrun", 32'(underrun), 32'd0);
    chk("expiry_grant_valid", 32'(m_valid), 32'd1);
    chk("expiry_grant_src", 32'(m_src), 32'd1);
    src_valid = 4'h0;
    cycle();
    for (int k = 1; k <= 8; k++) begin
      cycle();
      chk("underrun_after_grant", 32'(underrun), 32'(k == 8));
    end

    // Reset while a word is held.
    src_valid = 4'b0100;
    m_ready = 1'b0;
    cycle();
    chk("pre_reset_valid", 32'(m_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_m_valid", 32'(m_valid), 32'd0);
    model_reset();
    src_valid = 4'hF;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cycle();
    cycle();
    chk("restart_src0", 32'(m_src), 32'd0);
    chk("restart_valid", 32'(m_valid), 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) src_enable = 4'($urandom);
      src_valid = 4'($urandom) & 4'($urandom) & 4'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NS; i++) d[i] = 16'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
